// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a req/ready bus with a
// bounded wait, holds the word for decode and computes the next PC on advance.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0180,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic          clock,
  input  logic          reset,
  fetch_unit_if.master  imem,
  output logic [31:0]   inst,
  output logic          inst_valid,
  output logic [31:0]   pc,
  output logic [31:0]   pc4,
  input  logic          advance,
  input  logic [1:0]    control_type,
  input  logic          except,
  input  logic [31:0]   rs_data,
  output logic          addr_exc,
  output logic          fetch_err
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_REQ,
    S_HOLD,
    S_ERR
  } state_t;

  state_t           state, state_n;
  logic [31:0]      pc_n;
  logic [31:0]      inst_n;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_n;
  logic             addr_exc_n;

  logic [31:0]      branch_off;
  logic [31:0]      target;
  logic             misaligned;
  logic [31:0]      redirect;

  // Next-PC datapath: decoder selection, then misalignment redirect
  always_comb begin
    pc4        = pc + 32'd4;
    branch_off = {{14{inst[15]}}, inst[15:0], 2'b00};
    if (except) begin
      target = EXC_VECTOR;
    end else begin
      unique case (control_type)
        2'd0:    target = pc4;
        2'd1:    target = pc4 + branch_off;
        2'd2:    target = {pc4[31:28], inst[25:0], 2'b00};
        default: target = rs_data;
      endcase
    end
    misaligned = |target[1:0];
    redirect   = misaligned ? EXC_VECTOR : target;
  end

  // Next-state and register-update logic for the fetch FSM
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    inst_n     = inst;
    wait_cnt_n = wait_cnt;
    addr_exc_n = 1'b0;
    unique case (state)
      S_REQ: begin
        if (imem.imem_ready) begin
          inst_n     = imem.imem_rdata;
          wait_cnt_n = '0;
          state_n    = S_HOLD;
        end else begin
          wait_cnt_n = wait_cnt + CNT_W'(1);
          if (wait_cnt == CNT_LAST) begin
            state_n = S_ERR;
          end
        end
      end
      S_HOLD: begin
        if (advance) begin
          pc_n       = redirect;
          addr_exc_n = misaligned;
          state_n    = S_REQ;
        end
      end
      default: begin
        state_n = S_ERR;
      end
    endcase
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= S_REQ;
      pc       <= RESET_PC;
      inst     <= '0;
      wait_cnt <= '0;
      addr_exc <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      inst     <= inst_n;
      wait_cnt <= wait_cnt_n;
      addr_exc <= addr_exc_n;
    end
  end

  // Bus and status outputs; request and valid are masked while reset is low
  always_comb begin
    imem.imem_req  = reset && (state == S_REQ);
    imem.imem_addr = pc;
    inst_valid     = reset && (state == S_HOLD);
    fetch_err      = (state == S_ERR);
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of mips_decode. It owns the PC register and fetches from a variable-latency instruction memory using a req/ready handshake. It holds the fetched word stable for the decoder and datapath. On `advance` it computes the next PC from the decoder's control_type/except outputs and from the held instruction.

Parameters:
RESET_PC, 32'h00400000, PC loaded on reset
EXC_VECTOR, 32'h80000180, PC loaded on except or on a misaligned target
TIMEOUT, 16, max cycles in REQ without imem_ready before fatal error (>=1)

Ports:
clock  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-low (0 = reset, sampled on clock edge)
imem_req  output  1  fetch request to instruction memory
imem_addr  output  32  byte address of fetch (= pc)
imem_ready  input  1  memory returns imem_rdata valid this cycle
imem_rdata  input  32  instruction word from memory
inst  output  32  held instruction to decoder (opcode = inst[31:26], funct = inst[5:0])
inst_valid  output  1  inst is valid and stable
pc  output  32  address of held instruction
pc4  output  32  pc + 4
advance  input  1  datapath has retired the held instruction
control_type  input  2  from decoder: 0 = pc+4, 1 = branch, 2 = jump, 3 = jr
except  input  1  from decoder: illegal/exceptional instruction
rs_data  input  32  register rs value, used as the jr target
addr_exc  output  1  one-cycle pulse: misaligned next-PC redirected to EXC_VECTOR
fetch_err  output  1  sticky memory-timeout error

Behaviour:
- States: REQ, HOLD, ERR. Reset (reset == 0 at an edge) forces:
  - state = REQ, pc = RESET_PC, inst = 0, wait_cnt = 0
  - addr_exc = 0, fetch_err = 0
  - imem_req and inst_valid are forced 0 combinationally while reset == 0.
- Reset mid-fetch or mid-hold discards the in-flight access. A late imem_ready is ignored.
- REQ state:
  - imem_req = 1, imem_addr = pc, inst_valid = 0.
  - imem_ready == 1 at an edge: inst <= imem_rdata, wait_cnt <= 0, go to HOLD. Best case, inst_valid rises 1 cycle after entering REQ.
  - imem_ready == 0 at an edge: wait_cnt increments. When wait_cnt reaches TIMEOUT-1 with no ready, go to ERR.
- HOLD state:
  - imem_req = 0, inst_valid = 1. inst and pc are held stable; imem_ready is ignored.
  - advance == 1 at an edge: pc <= next_pc, go to REQ. advance is ignored in REQ and ERR.
- next_pc selection, in priority order:
  1. except == 1 -> EXC_VECTOR. Overrides control_type.
  2. control_type 0 -> pc4.
  3. control_type 1 -> pc4 + (sign_extend(inst[15:0]) << 2), 32-bit wraparound.
  4. control_type 2 -> {pc4[31:28], inst[25:0], 2'b00}.
  5. control_type 3 -> rs_data.
- Misaligned target: if the selected next_pc[1:0] != 0, pc <= EXC_VECTOR instead and addr_exc = 1 for exactly the cycle after the advance edge.
- pc4 = pc + 4, wrapping modulo 2^32 (pc 32'hFFFFFFFC gives pc4 = 0).
- ERR state:
  - fetch_err = 1, imem_req = 0, inst_valid = 0.
  - Absorbing; left only by reset.

Test Plan:
- Reset and sequential fetch: reset low for 2 cycles, then imem_ready = 1 every cycle, rdata = 32'h00000020, control_type = 0, advance pulsed in each HOLD -> imem_addr sequence 0x00400000, 0x00400004, 0x00400008; inst_valid rises 1 cycle after each REQ.
- Branch backward: pc = 0x00400000, inst = 32'h1000FFFF, control_type = 1, advance -> next imem_addr = 0x00400000. Same with inst[15:0] = 0x0003 -> 0x00400010.
- Jump and jr: inst = 32'h08100010, control_type = 2 -> 0x00400040. control_type = 3 with rs_data = 0x00400100 -> 0x00400100. control_type = 3 with rs_data = 0x00400101 -> 0x80000180 and a single addr_exc pulse.
- except priority: except = 1 with control_type = 2 -> 0x80000180; addr_exc stays 0.
- Wait states and timeout (TIMEOUT = 4):
  - imem_ready low 2 cycles then high -> captured inst correct; inst_valid stays 0 during the wait; advance asserted during REQ has no effect.
  - imem_ready held low -> fetch_err = 1 after 4 REQ cycles, imem_req = 0; stays in ERR until reset.
- Reset mid-wait: reset asserted while in REQ, then imem_ready = 1 on the cycle after reset release with a new rdata -> pc = 0x00400000 and inst = the new rdata; the stale word is never captured.
